// File: rtl/flp_div_pkg.sv
// Shared types and constants for the floating-point divider arbitration controller.
package flp_div_pkg;

    localparam int unsigned FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return int'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter
    import flp_div_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]           req_i,
    input  logic [ptr_w(NREQ)-1:0]    ptr_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [ptr_w(NREQ)-1:0]    gnt_idx_o
);

    localparam int unsigned PW = ptr_w(NREQ);
    localparam int unsigned EW = PW + 1;

    logic [EW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = EW'(ptr_i) + EW'(i);
            if (idx >= EW'(NREQ)) begin
                idx = idx - EW'(NREQ);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found                = 1'b1;
                gnt_o[idx[PW-1:0]]   = 1'b1;
                gnt_idx_o            = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/flp_div_arbiter.sv
// Shares one sequential FP divider among NREQ requesters: round-robin grant,
// load/run sequencing, watchdog abort, and valid/ready result return.
module flp_div_arbiter
    import flp_div_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAX_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [FP_W*NREQ-1:0]   req_a,
    input  logic [FP_W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [FP_W-1:0]        resp_q,
    output logic                   resp_err,
    input  logic [NREQ-1:0]        resp_ready,
    output logic                   div_rst,
    output logic [FP_W-1:0]        div_a,
    output logic [FP_W-1:0]        div_b,
    input  logic [FP_W-1:0]        div_q,
    input  logic                   div_done
);

    localparam int unsigned PW = ptr_w(NREQ);
    localparam int unsigned CW = ptr_w(MAX_CYC);

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [NREQ-1:0]   goh_q, goh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FP_W-1:0]   div_a_q, div_a_d;
    logic [FP_W-1:0]   div_b_q, div_b_d;
    logic [FP_W-1:0]   quot_q, quot_d;
    logic              err_q, err_d;
    logic [NREQ-1:0]   resp_vld_q, resp_vld_d;
    logic              div_rst_q, div_rst_d;

    logic [NREQ-1:0]   gnt_oh;
    logic [PW-1:0]     gnt_idx;
    logic [FP_W-1:0]   sel_a, sel_b;
    logic [PW-1:0]     ptr_next;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    // Operand mux for the current arbitration winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_a = req_a[i*FP_W +: FP_W];
                sel_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    assign ptr_next = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        goh_d      = goh_q;
        cnt_d      = cnt_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        quot_d     = quot_q;
        err_d      = err_q;
        resp_vld_d = '0;
        div_rst_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gidx_d  = gnt_idx;
                    goh_d   = gnt_oh;
                    div_a_d = sel_a;
                    div_b_d = sel_b;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                // A done seen in the first RUN cycle may be left over from the previous op.
                if ((cnt_q != '0) && div_done) begin
                    quot_d  = div_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(MAX_CYC - 1)) begin
                    quot_d  = FP_QNAN;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (|(resp_ready & goh_q)) begin
                    rr_ptr_d = ptr_next;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        div_rst_d  = (state_d != RUN);
        resp_vld_d = (state_d == RESP) ? goh_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            goh_q      <= '0;
            cnt_q      <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            quot_q     <= '0;
            err_q      <= 1'b0;
            resp_vld_q <= '0;
            div_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            goh_q      <= goh_d;
            cnt_q      <= cnt_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            quot_q     <= quot_d;
            err_q      <= err_d;
            resp_vld_q <= resp_vld_d;
            div_rst_q  <= div_rst_d;
        end
    end

    // Operand accept is combinational so the requester sees it in the grant cycle.
    assign req_ready  = ((state_q == IDLE) && rst) ? gnt_oh : '0;
    assign resp_valid = resp_vld_q;
    assign resp_q     = quot_q;
    assign resp_err   = err_q;
    assign div_rst    = div_rst_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;

endmodule

// File: tb/tb_flp_div_arbiter.sv
// Directed bench for flp_div_arbiter with a behavioural divider model.
module tb_flp_div_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned MC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [32*NR-1:0] req_a, req_b;
    logic [31:0]     resp_q, div_a, div_b, div_q;
    logic            resp_err, div_rst, div_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int run_cnt  = 0;
    int mode     = 0;
    int lat_l    = 2;

    flp_div_arbiter #(.NREQ(NR), .MAX_CYC(MC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_q(resp_q), .resp_err(resp_err), .resp_ready(resp_ready),
        .div_rst(div_rst), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_done(div_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        run_cnt <= div_rst ? 0 : run_cnt + 1;
    end

    // Hand-computed quotients for the operand pairs used here.
    function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h41A00000_40800000: return 32'h40A00000;
            64'h40C00000_40000000: return 32'h40400000;
            64'h41000000_40000000: return 32'h40800000;
            64'h3F800000_3F800000: return 32'h3F800000;
            64'h40400000_40400000: return 32'h3F800000;
            default:               return a ^ b;
        endcase
    endfunction

    // mode 0: done after lat_l RUN cycles; 1: never done; 2: stale done then real done.
    always_comb begin
        div_done = 1'b0;
        div_q    = 32'h0BAD0BAD;
        case (mode)
            0: if (!div_rst && run_cnt >= lat_l) begin
                div_done = 1'b1;
                div_q    = model_q(div_a, div_b);
            end
            2: begin
                if (div_rst || run_cnt == 0) begin
                    div_done = 1'b1;
                    div_q    = 32'hDEADBEEF;
                end else if (run_cnt >= 4) begin
                    div_done = 1'b1;
                    div_q    = 32'h3F800000;
                end
            end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic wait_resp(input int start, output int lat, output int runs, output bit ok);
        ok = 1'b0; lat = 0; runs = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (resp_valid != '0) begin
                ok  = 1'b1;
                lat = cyc - start;
                break;
            end
            if (!div_rst) runs++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
        step(); step();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        n_checks++; if (resp_q !== 32'h0) begin n_fail++; $display("FAIL reset_resp_q: got %h want 0", resp_q); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_checks++; if (div_rst !== 1'b1) begin n_fail++; $display("FAIL reset_div_rst: got %b want 1", div_rst); end
        n_checks++; if (div_a !== 32'h0) begin n_fail++; $display("FAIL reset_div_a: got %h want 0", div_a); end
        n_checks++; if (div_b !== 32'h0) begin n_fail++; $display("FAIL reset_div_b: got %h want 0", div_b); end
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_no_grant: got %b want 0000", req_ready); end
        req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single_op();
        int g, lat, runs; bit ok;
        mode = 0; lat_l = 2; resp_ready = 4'b1111;
        set_req(0, 32'h41A00000, 32'h40800000);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        g = cyc;
        step();
        req_valid = '0;
        n_checks++; if (div_rst !== 1'b1) begin n_fail++; $display("FAIL single_load_div_rst: got %b want 1", div_rst); end
        n_checks++; if (div_a !== 32'h41A00000) begin n_fail++; $display("FAIL single_div_a: got %h want 41a00000", div_a); end
        n_checks++; if (div_b !== 32'h40800000) begin n_fail++; $display("FAIL single_div_b: got %h want 40800000", div_b); end
        step();
        n_checks++; if (div_rst !== 1'b0) begin n_fail++; $display("FAIL single_run_div_rst: got %b want 0", div_rst); end
        wait_resp(g, lat, runs, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_timeout: no resp_valid want within 60 cycles");
        end else begin
            if (lat !== 5) begin n_fail++; $display("FAIL single_latency: got %0d want 5", lat); end
            n_checks++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_resp_valid: got %b want 0001", resp_valid); end
            n_checks++; if (resp_q !== 32'h40A00000) begin n_fail++; $display("FAIL single_resp_q: got %h want 40a00000", resp_q); end
            n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL single_resp_err: got %b want 0", resp_err); end
        end
        step();
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_one_cycle_resp: got %b want 0000", resp_valid); end
        n_checks++; if (div_rst !== 1'b1) begin n_fail++; $display("FAIL single_idle_div_rst: got %b want 1", div_rst); end
    endtask

    task automatic test_contention();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [31:0] exp_q [4] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h3F800000};
        int ngr, nresp, cur, prev, gi;
        bit drop;
        ngr = 0; nresp = 0; cur = 0; prev = 0; drop = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        mode = 0; lat_l = 1; resp_ready = 4'b1111;
        set_req(0, 32'h40C00000, 32'h40000000);
        set_req(1, 32'h41000000, 32'h40000000);
        set_req(2, 32'h41A00000, 32'h40800000);
        set_req(3, 32'h3F800000, 32'h3F800000);
        #1;
        for (int k = 0; k < 80; k++) begin
            if (req_ready != '0) begin
                gi = 0;
                for (int i = 0; i < int'(NR); i++) if (req_ready[i]) gi = i;
                n_checks++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL cont_onehot: got %b want one-hot", req_ready); end
                if (ngr < 5) begin
                    n_checks++; if (gi !== exp_g[ngr]) begin n_fail++; $display("FAIL cont_order%0d: got %0d want %0d", ngr, gi, exp_g[ngr]); end
                end
                if (ngr > 0) begin
                    n_checks++; if (cyc - prev !== 5) begin n_fail++; $display("FAIL cont_period%0d: got %0d want 5", ngr, cyc - prev); end
                end
                prev = cyc; cur = gi; ngr++;
                if (ngr == 5) drop = 1'b1;
            end
            if (resp_valid != '0) begin
                n_checks++; if (resp_valid !== NR'(1 << cur)) begin n_fail++; $display("FAIL cont_resp_valid: got %b want index %0d", resp_valid, cur); end
                n_checks++; if (resp_q !== exp_q[cur]) begin n_fail++; $display("FAIL cont_resp_q: got %h want %h", resp_q, exp_q[cur]); end
                nresp++;
            end
            if (nresp == 5) break;
            step();
            if (drop) begin req_valid = '0; drop = 1'b0; #1; end
        end
        n_checks++; if (ngr !== 5) begin n_fail++; $display("FAIL cont_grants: got %0d want 5", ngr); end
        n_checks++; if (nresp !== 5) begin n_fail++; $display("FAIL cont_resps: got %0d want 5", nresp); end
        req_valid = '0;
        step();
    endtask

    task automatic test_stale_done();
        int g, lat, runs; bit ok;
        mode = 2;
        set_req(1, 32'h40400000, 32'h40400000);
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stale_grant: got %b want 0010", req_ready); end
        g = cyc;
        step();
        req_valid = '0;
        wait_resp(g, lat, runs, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL stale_timeout: no resp_valid want within 60 cycles");
        end else begin
            if (lat !== 7) begin n_fail++; $display("FAIL stale_latency: got %0d want 7", lat); end
            n_checks++; if (resp_q !== 32'h3F800000) begin n_fail++; $display("FAIL stale_resp_q: got %h want 3f800000", resp_q); end
            n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL stale_resp_err: got %b want 0", resp_err); end
        end
        step();
    endtask

    task automatic test_watchdog();
        int g, lat, runs; bit ok;
        mode = 1;
        set_req(2, 32'h41A00000, 32'h00000000);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wd_grant: got %b want 0100", req_ready); end
        g = cyc;
        step();
        req_valid = '0;
        wait_resp(g, lat, runs, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL wd_timeout: no resp_valid want within 60 cycles");
        end else begin
            if (lat !== 18) begin n_fail++; $display("FAIL wd_latency: got %0d want 18", lat); end
            n_checks++; if (runs !== 16) begin n_fail++; $display("FAIL wd_run_cycles: got %0d want 16", runs); end
            n_checks++; if (resp_q !== 32'h7FC00000) begin n_fail++; $display("FAIL wd_resp_q: got %h want 7fc00000", resp_q); end
            n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL wd_resp_err: got %b want 1", resp_err); end
            n_checks++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL wd_resp_valid: got %b want 0100", resp_valid); end
        end
        step();
    endtask

    task automatic test_backpressure();
        int g, lat, runs; bit ok;
        mode = 0; lat_l = 1; resp_ready = 4'b1011;
        set_req(2, 32'h41000000, 32'h40000000);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        g = cyc;
        step();
        req_valid = '0;
        set_req(0, 32'h40C00000, 32'h40000000);
        wait_resp(g, lat, runs, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_timeout: no resp_valid want within 60 cycles");
        end else if (lat !== 4) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 4", lat);
        end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b want 0100", k, resp_valid); end
            n_checks++; if (resp_q !== 32'h40800000) begin n_fail++; $display("FAIL bp_hold_q%0d: got %h want 40800000", k, resp_q); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant%0d: got %b want 0000", k, req_ready); end
            n_checks++; if (div_rst !== 1'b1) begin n_fail++; $display("FAIL bp_div_rst%0d: got %b want 1", k, div_rst); end
            step();
        end
        resp_ready = 4'b0100;
        step();
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got %b want 0000", resp_valid); end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
        resp_ready = 4'b1111;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        seen = 1'b0;
        mode = 1;
        step();
        req_valid = '0;
        step(); step(); step();
        n_checks++; if (div_rst !== 1'b0) begin n_fail++; $display("FAIL rmr_in_run: got div_rst %b want 0", div_rst); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmr_resp_valid: got %b want 0000", resp_valid); end
        n_checks++; if (resp_q !== 32'h0) begin n_fail++; $display("FAIL rmr_resp_q: got %h want 0", resp_q); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rmr_resp_err: got %b want 0", resp_err); end
        n_checks++; if (div_rst !== 1'b1) begin n_fail++; $display("FAIL rmr_div_rst: got %b want 1", div_rst); end
        n_checks++; if (div_a !== 32'h0) begin n_fail++; $display("FAIL rmr_div_a: got %h want 0", div_a); end
        n_checks++; if (div_b !== 32'h0) begin n_fail++; $display("FAIL rmr_div_b: got %h want 0", div_b); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmr_req_ready: got %b want 0000", req_ready); end
        for (int k = 0; k < 25; k++) begin
            step();
            if (resp_valid != '0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmr_no_resp: got resp_valid pulse want none"); end
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmr_ptr_reset: got %b want 0010", req_ready); end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_stale_done();
        test_watchdog();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/flp_div_arbiter.md
# flp_div_arbiter

Round-robin controller that shares one sequential floating-point divider among `NREQ` requesters. It arbitrates requests and latches the winner's operands. It then sequences the divider through its load (reset-held) phase and run phase, waits for `div_done`, and returns the quotient to the winning requester over a valid/ready response handshake. A watchdog aborts a hung division and returns a quiet NaN with an error flag.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `MAX_CYC`, 64, watchdog limit in RUN cycles before abort
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — reset, synchronous, active-low
- `req_valid` in NREQ — requester i has operands ready
- `req_a` in 32·NREQ — packed dividend, requester i at [32i+31:32i]
- `req_b` in 32·NREQ — packed divisor, same packing
- `req_ready` out NREQ — one-hot; operand accept for granted requester
- `resp_valid` out NREQ — one-hot; result available for requester i
- `resp_q` out 32 — quotient (IEEE-754 single)
- `resp_err` out 1 — 1 = watchdog abort, `resp_q` = 0x7FC00000
- `resp_ready` in NREQ — requester i accepts result
- `div_rst` out 1 — active-high hold/load to divider
- `div_a`, `div_b` out 32 each — registered operands to divider
- `div_q` in 32 — divider quotient
- `div_done` in 1 — divider completion level

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any `req_valid`, grant the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch `req_a`/`req_b` of g into `div_a`/`div_b` and latch g; go to LOAD.
  - If no request, stay in IDLE.
- LOAD: exactly one cycle with `div_rst`=1 and operands stable; go to RUN and clear the watchdog counter.
- RUN:
  - `div_rst`=0; counter increments each cycle.
  - `div_done` is ignored in the first RUN cycle, which guards against stale done from the previous operation.
  - From the second RUN cycle on, `div_done`=1 latches `div_q` into `resp_q`, sets `resp_err`=0, and goes to RESP.
  - If the counter reaches MAX_CYC first, set `resp_q`=0x7FC00000 and `resp_err`=1, then go to RESP.
- RESP:
  - Hold `resp_valid[g]`=1, with `resp_q`/`resp_err` stable, until `resp_ready[g]`=1.
  - On that handshake, set `rr_ptr` ← (g+1) mod NREQ and go to IDLE.
  - `div_rst` is driven 1 in RESP and IDLE so the divider idles in reset.
- Only one operation is in flight at a time; no queueing.
- A requester deasserting `req_valid` while not granted is legal. Once its `req_ready` pulses, the operands are owned by the controller.
- `resp_ready` on a non-granted index is ignored.
- `rst` low in any state: next state IDLE, operation discarded, no response.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0
  - `req_ready`=0, `resp_valid`=0, `resp_q`=0, `resp_err`=0
  - `div_rst`=1, `div_a`=`div_b`=0
- Latency from grant cycle to first `resp_valid`: 2 + D cycles.
  - D = RUN cycles until the first qualifying `div_done`, minimum 2.
  - D = MAX_CYC on abort.
- IDLE→IDLE back-to-back: next grant can occur the cycle after the RESP handshake.
- Minimum period per operation: 1 (IDLE) + 1 (LOAD) + D + 1 (RESP).
- Simultaneous `req_valid` on several lines: the lowest index ≥ `rr_ptr` wins, others wait.
- The granted requester's own `req_valid` in later cycles has no effect until the next IDLE.
- `resp_ready` already high on RESP entry: handshake completes in that first RESP cycle (`resp_valid` high one cycle).
- Watchdog: abort fires on the RUN cycle where counter == MAX_CYC−1. Counter width is clog2(MAX_CYC).

## Structure
- Package `flp_div_pkg`:
  - state enum (IDLE, LOAD, RUN, RESP)
  - `FP_QNAN` = 32'h7FC0_0000
  - `FP_W` = 32
  - function computing pointer width clog2(NREQ)
- Sub-module `rr_arbiter`:
  - combinational one-hot grant from a request vector and a pointer
  - parameter NREQ
  - reused by other shared-datapath controllers
- Top instantiates `rr_arbiter` plus the FSM, operand/result registers and watchdog counter. The divider itself is instantiated outside and connected via the `div_*` ports.

## Test plan
- Single op: requester 0 sends a=0x41A00000 (20.0), b=0x40800000 (4.0) with a real divider attached → `resp_valid[0]`, `resp_q`=0x40A00000 (5.0), `resp_err`=0.
- Contention: all four `req_valid` high after reset → grants in order 0,1,2,3,0. Each grant only after the previous RESP handshake; `req_ready` always one-hot.
- Stale-done guard: divider model holds `div_done`=1 through LOAD and the first RUN cycle, then 0 for 3 cycles, then 1 with q=0x3F800000 → `resp_q`=0x3F800000, not a stale value.
- Watchdog: divider model never asserts done, MAX_CYC=16 → `resp_q`=0x7FC00000, `resp_err`=1 after exactly 16 RUN cycles.
- Response backpressure: hold `resp_ready[2]`=0 for 10 cycles → `resp_valid[2]` and `resp_q` stable throughout, no new grant, `div_rst`=1.
- Reset mid-RUN: drive `rst`=0 for one edge during RUN → next cycle IDLE, all outputs at reset values, no `resp_valid` pulse for the aborted op.
